// File: rtl/tpu_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_layer_sequencer_pkg
// Brief    : TPU register map, sequencer/APB state encodings and done-bit index
// Revision : 1.0
// ============================================================================
package tpu_layer_sequencer_pkg;

    localparam logic [7:0] REG_STDN_TPU_ADDR = 8'h00;
    localparam logic [7:0] REG_ENABLES_ADDR  = 8'h04;
    localparam logic [7:0] REG_MEAN_ADDR     = 8'h08;
    localparam logic [7:0] REG_INV_VAR_ADDR  = 8'h0C;
    localparam logic [7:0] REG_MATRIX_A_ADDR = 8'h10;
    localparam logic [7:0] REG_MATRIX_B_ADDR = 8'h14;
    localparam logic [7:0] REG_MATRIX_C_ADDR = 8'h18;

    localparam int DONE_BIT = 31;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_EN   = 4'd1,
        ST_W_MEAN = 4'd2,
        ST_W_INV  = 4'd3,
        ST_W_A    = 4'd4,
        ST_W_B    = 4'd5,
        ST_W_C    = 4'd6,
        ST_W_GO   = 4'd7,
        ST_POLL   = 4'd8,
        ST_W_STOP = 4'd9,
        ST_NEXT   = 4'd10,
        ST_FIN    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_t;

endpackage
`default_nettype wire

// File: rtl/tpu_layer_sequencer_apb.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_port
// Brief    : Single-outstanding APB master: SETUP, ACCESS until PREADY, idle
// Revision : 1.0
// ============================================================================
module apb_master_port
    import tpu_layer_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] PADDR,
    output logic          PWRITE,
    output logic          PSEL,
    output logic          PENABLE,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY
);

    apb_phase_t r_phase;

    // req is only honoured in the idle phase; the caller waits for ack
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase <= PH_IDLE;
            ack     <= 1'b0;
            rdata   <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWDATA  <= '0;
        end else begin
            ack <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (req) begin
                        PSEL    <= 1'b1;
                        PWRITE  <= wr;
                        PADDR   <= addr;
                        PWDATA  <= wdata;
                        r_phase <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    PENABLE <= 1'b1;
                    r_phase <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (PREADY) begin
                        rdata   <= PRDATA;
                        ack     <= 1'b1;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= '0;
                        PWDATA  <= '0;
                        r_phase <= PH_IDLE;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tpu_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_layer_sequencer
// Brief    : Descriptor-driven APB sequencer running multi-layer TPU inference
// Revision : 1.0
// ============================================================================
module tpu_layer_sequencer
    import tpu_layer_sequencer_pkg::*;
#(
    parameter int MAX_LAYERS    = 8,
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter int AWIDTH        = 10,
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT       = 4096
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(MAX_LAYERS):0]   num_layers,
    input  logic [3:0]                    enables,
    input  logic [7:0]                    mean,
    input  logic [7:0]                    inv_var,
    input  logic                          desc_we,
    input  logic [$clog2(MAX_LAYERS)-1:0] desc_idx,
    input  logic [AWIDTH-1:0]             desc_a,
    input  logic [AWIDTH-1:0]             desc_b,
    input  logic [AWIDTH-1:0]             desc_c,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          aborted,
    output logic [$clog2(MAX_LAYERS)-1:0] cur_layer,
    output logic [REG_ADDRWIDTH-1:0]      PADDR,
    output logic                          PWRITE,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic [REG_DATAWIDTH-1:0]      PWDATA,
    input  logic [REG_DATAWIDTH-1:0]      PRDATA,
    input  logic                          PREADY
);

    localparam int c_LAYER_W = $clog2(MAX_LAYERS);
    localparam int c_NUM_W   = c_LAYER_W + 1;
    localparam int c_POLL_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_GAP_W   = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    logic [AWIDTH-1:0] r_desc_a [MAX_LAYERS];
    logic [AWIDTH-1:0] r_desc_b [MAX_LAYERS];
    logic [AWIDTH-1:0] r_desc_c [MAX_LAYERS];

    state_t                   r_state;
    logic                     r_busy, r_done, r_error, r_aborted;
    logic [c_LAYER_W-1:0]     r_cur_layer;
    logic [c_NUM_W-1:0]       r_num;
    logic                     r_pending, r_go_active, r_abort_seen;
    logic [c_POLL_W-1:0]      r_polls;
    logic [c_GAP_W-1:0]       r_gap;

    logic                     w_req, w_wr, w_ack, w_xfer, w_abortable, w_abort_now;
    logic [REG_ADDRWIDTH-1:0] w_addr;
    logic [REG_DATAWIDTH-1:0] w_wdata, w_rdata;
    logic [c_NUM_W-1:0]       w_next_cnt;
    logic                     w_unused_rdata;

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign aborted   = r_aborted;
    assign cur_layer = r_cur_layer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                r_desc_a[i] <= '0;
                r_desc_b[i] <= '0;
                r_desc_c[i] <= '0;
            end
        end else if (desc_we && !r_busy) begin
            r_desc_a[desc_idx] <= desc_a;
            r_desc_b[desc_idx] <= desc_b;
            r_desc_c[desc_idx] <= desc_c;
        end
    end

    assign w_xfer      = (r_state inside {ST_W_EN, ST_W_MEAN, ST_W_INV, ST_W_A, ST_W_B,
                                          ST_W_C, ST_W_GO, ST_POLL, ST_W_STOP});
    assign w_abortable = w_xfer && (r_state != ST_W_STOP);
    assign w_abort_now = r_abort_seen || abort;
    // A pending abort suppresses new requests but never cuts one short
    assign w_req       = w_xfer && !r_pending && !(w_abortable && w_abort_now)
                         && !((r_state == ST_POLL) && (r_gap != '0));
    assign w_next_cnt  = c_NUM_W'(r_cur_layer) + c_NUM_W'(1);
    assign w_unused_rdata = &{1'b0, w_rdata};

    always_comb begin
        w_wr    = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            ST_W_EN:   begin w_addr = REG_ADDRWIDTH'(REG_ENABLES_ADDR);  w_wdata = REG_DATAWIDTH'(enables); end
            ST_W_MEAN: begin w_addr = REG_ADDRWIDTH'(REG_MEAN_ADDR);     w_wdata = REG_DATAWIDTH'(mean); end
            ST_W_INV:  begin w_addr = REG_ADDRWIDTH'(REG_INV_VAR_ADDR);  w_wdata = REG_DATAWIDTH'(inv_var); end
            ST_W_A:    begin w_addr = REG_ADDRWIDTH'(REG_MATRIX_A_ADDR); w_wdata = REG_DATAWIDTH'(r_desc_a[r_cur_layer]); end
            ST_W_B:    begin w_addr = REG_ADDRWIDTH'(REG_MATRIX_B_ADDR); w_wdata = REG_DATAWIDTH'(r_desc_b[r_cur_layer]); end
            ST_W_C:    begin w_addr = REG_ADDRWIDTH'(REG_MATRIX_C_ADDR); w_wdata = REG_DATAWIDTH'(r_desc_c[r_cur_layer]); end
            ST_W_GO:   begin w_addr = REG_ADDRWIDTH'(REG_STDN_TPU_ADDR); w_wdata = REG_DATAWIDTH'(1); end
            ST_POLL:   begin w_addr = REG_ADDRWIDTH'(REG_STDN_TPU_ADDR); w_wr = 1'b0; end
            ST_W_STOP: begin w_addr = REG_ADDRWIDTH'(REG_STDN_TPU_ADDR); end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
            r_cur_layer  <= '0;
            r_num        <= '0;
            r_pending    <= 1'b0;
            r_go_active  <= 1'b0;
            r_abort_seen <= 1'b0;
            r_polls      <= '0;
            r_gap        <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) r_abort_seen <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state      <= ST_W_EN;
                        r_busy       <= 1'b1;
                        r_error      <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_cur_layer  <= '0;
                        r_go_active  <= 1'b0;
                        r_abort_seen <= 1'b0;
                        r_pending    <= 1'b0;
                        r_num        <= (num_layers > c_NUM_W'(MAX_LAYERS)) ? c_NUM_W'(MAX_LAYERS) : num_layers;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_NEXT: begin
                    r_cur_layer <= r_cur_layer + 1'b1;
                    r_state     <= (w_next_cnt == r_num) ? ST_FIN : ST_W_A;
                end
                default: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end else if (w_ack) begin
                        r_pending <= 1'b0;
                        case (r_state)
                            ST_W_EN:   r_state <= ST_W_MEAN;
                            ST_W_MEAN: r_state <= ST_W_INV;
                            ST_W_INV:  r_state <= (r_num == '0) ? ST_FIN : ST_W_A;
                            ST_W_A:    r_state <= ST_W_B;
                            ST_W_B:    r_state <= ST_W_C;
                            ST_W_C:    r_state <= ST_W_GO;
                            ST_W_GO: begin
                                r_go_active <= 1'b1;
                                r_polls     <= '0;
                                r_gap       <= '0;
                                r_state     <= ST_POLL;
                            end
                            ST_POLL: begin
                                if (w_rdata[DONE_BIT]) begin
                                    r_state <= ST_W_STOP;
                                end else if (r_polls == c_POLL_W'(TIMEOUT - 1)) begin
                                    r_error <= 1'b1;
                                    r_state <= ST_W_STOP;
                                end else begin
                                    r_polls <= r_polls + 1'b1;
                                    r_gap   <= c_GAP_W'(POLL_GAP);
                                end
                            end
                            ST_W_STOP: begin
                                r_go_active <= 1'b0;
                                if (w_abort_now) r_aborted <= 1'b1;
                                r_state <= (r_error || w_abort_now) ? ST_FIN : ST_NEXT;
                            end
                            default: r_state <= ST_FIN;
                        endcase
                    end else if (!r_pending && w_abortable && w_abort_now) begin
                        // Layer already started must be stopped before finishing
                        r_aborted <= 1'b1;
                        r_state   <= r_go_active ? ST_W_STOP : ST_FIN;
                    end else if ((r_state == ST_POLL) && !r_pending && (r_gap != '0)) begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
            endcase
        end
    end

    apb_master_port #(
        .AW (REG_ADDRWIDTH),
        .DW (REG_DATAWIDTH)
    ) u_apb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (w_req),
        .wr      (w_wr),
        .addr    (w_addr),
        .wdata   (w_wdata),
        .ack     (w_ack),
        .rdata   (w_rdata),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

endmodule
`default_nettype wire

// File: doc/tpu_layer_sequencer.md
Name: tpu_layer_sequencer

Overview:
APB master that runs a multi-layer inference on the TPU without host polling. The host loads a small descriptor table of per-layer matrix A/B/C base addresses and pulses start. The block then programs the TPU configuration block over APB, starts each layer, polls the done bit, and stops the layer before the next one. It sits between the host/system controller and the TPU's APB slave port.

Parameters:
MAX_LAYERS, 8, descriptor table depth (power of 2)
REG_ADDRWIDTH, 8, APB address width
REG_DATAWIDTH, 32, APB data width
AWIDTH, 10, BRAM address width held per descriptor field
POLL_GAP, 4, idle cycles between done-poll reads
TIMEOUT, 4096, maximum done-poll reads per layer before error

Ports:
clk  in  1  the single clock
resetn  in  1  asynchronous active-low reset; its polarity and asynchronous behaviour are fixed
start  in  1  single-cycle pulse; honoured only in IDLE
abort  in  1  level; requests an orderly stop
num_layers  in  $clog2(MAX_LAYERS)+1  number of layers to run, latched on start
enables  in  4  value written to REG_ENABLES_ADDR
mean  in  8  value written to REG_MEAN_ADDR
inv_var  in  8  value written to REG_INV_VAR_ADDR
desc_we  in  1  descriptor write strobe
desc_idx  in  $clog2(MAX_LAYERS)  descriptor index
desc_a, desc_b, desc_c  in  AWIDTH each  matrix A, B and C base addresses
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse when the sequence ends (normal, abort or error)
error  out  1  sticky timeout flag; cleared by the next accepted start
aborted  out  1  sticky abort flag; cleared by the next accepted start
cur_layer  out  $clog2(MAX_LAYERS)  index of the layer in progress
PADDR  out  REG_ADDRWIDTH  APB address
PWRITE, PSEL, PENABLE  out  1 each  APB controls
PWDATA  out  REG_DATAWIDTH  APB write data
PRDATA  in  REG_DATAWIDTH  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the descriptor table is cleared to 0.
- APB transfer: one cycle of SETUP (PSEL=1, PENABLE=0), then ACCESS (PENABLE=1), held until PREADY=1. On the PREADY cycle the read data is sampled. The next cycle drives PSEL, PENABLE, PWRITE, PADDR and PWDATA to 0. Every transfer therefore takes at least 3 cycles. PWDATA is zero-extended.
- Descriptor writes are accepted only when busy=0; when busy=1 they are dropped.
- FSM: IDLE -> W_EN -> W_MEAN -> W_INV -> (per layer) W_A -> W_B -> W_C -> W_GO (write 1 to REG_STDN_TPU_ADDR) -> POLL -> W_STOP (write 0) -> NEXT -> FIN -> IDLE.
- POLL reads REG_STDN_TPU_ADDR.
  - If PRDATA[31]=1, go to W_STOP.
  - Otherwise wait POLL_GAP cycles and read again.
  - If TIMEOUT reads complete with no done bit, set error and go to W_STOP, then FIN. Remaining layers are skipped.
- NEXT increments cur_layer. If the count equals num_layers, go to FIN; otherwise go to W_A.
- FIN pulses done for one cycle and returns to IDLE; busy drops in the same cycle.
- num_layers=0: the config writes still occur, then FIN. No layer traffic.
- num_layers>MAX_LAYERS is clamped to MAX_LAYERS.
- abort:
  - Sampled in every non-IDLE state, but an in-flight APB transfer always completes first.
  - If REG_STDN_TPU_ADDR=1 has been written and not yet cleared, abort goes next to W_STOP, then FIN, with aborted=1.
  - Otherwise abort goes directly to FIN.
- start while busy is ignored. Simultaneous start and abort in IDLE: start is ignored.
- Descriptor fields are read combinationally from the table using cur_layer.

Decomposition:
- The shared package holds the register-address constants (REG_ENABLES_ADDR, REG_MEAN_ADDR, REG_INV_VAR_ADDR, REG_MATRIX_A/B/C_ADDR, REG_STDN_TPU_ADDR), the state enum, and the done-bit index 31.
- One sub-module, apb_master_port, implements the SETUP/ACCESS/idle handshake with req/wr/addr/wdata inputs and ack/rdata outputs.

Test Plan:
- Reset: assert resetn=0 mid-transfer -> PSEL=0, PENABLE=0, busy=0 asynchronously; the table reads back 0.
- Two layers: descriptors {0x08,0x00,0x20} and {0x20,0x00,0x40}, start with num_layers=2, a slave model raising bit31 after 50 cycles -> the APB write sequence is ENABLES=0xF, MEAN=1, INV_VAR=1, then per layer A/B/C, STDN=1, polls, STDN=0. done pulses once and error=0.
- Wait states: PREADY low for 3 cycles on each access -> PENABLE is held 4 cycles and the same transaction order results.
- Timeout: TIMEOUT=8 and the slave never sets bit31 -> exactly 8 poll reads, then a STDN=0 write, error=1, done pulse, layer 1 never started.
- Abort during POLL of layer 0 -> the current read completes, then a STDN=0 write, aborted=1, done pulse.
- num_layers=0 -> only the 3 config writes, then done. A start while busy and desc_we while busy are ignored; the table is unchanged.
